// File: rtl/conta_pkg.sv
// Shared constants and helpers for the conta_up_down_mod counter family.
package conta_pkg;

    localparam logic CONTA_UP   = 1'b1;
    localparam logic CONTA_DOWN = 1'b0;

    // Load values above the modulus are clamped to the top of the count range.
    function automatic logic [31:0] conta_clamp(input logic [31:0] value, input logic [31:0] max_val);
        return (value > max_val) ? max_val : value;
    endfunction

endpackage

// File: rtl/conta_limit_cmp.sv
// Combinational end-of-range detect.
// Kept separate so cascaded digit chains can reuse it.
module conta_limit_cmp #(
    parameter int          WIDTH   = 4,
    parameter int unsigned MAX_VAL = 9
) (
    input  logic [WIDTH-1:0] q,
    output logic             at_max,
    output logic             at_zero
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

    assign at_max  = (q == MAX_Q);
    assign at_zero = (q == '0);

endmodule

// File: rtl/conta_up_down_mod.sv
// Up/down modulo counter with clamped parallel load and a registered wrap pulse.
// Define CONTA_SATURATE_EN to saturate at 0/MAX_VAL instead of rolling over.
module conta_up_down_mod
    import conta_pkg::*;
#(
    parameter int          WIDTH   = 4,
    parameter int unsigned MAX_VAL = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    // 64-bit arithmetic so WIDTH=32 does not overflow the range check.
    if (64'(MAX_VAL) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
        $error("conta_up_down_mod: MAX_VAL does not fit in WIDTH bits");
    end

    logic [WIDTH-1:0] q_reg;
    logic             wrap_reg;
    logic             at_max;
    logic             at_zero;

    conta_limit_cmp #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL)
    ) u_limit (
        .q       (q_reg),
        .at_max  (at_max),
        .at_zero (at_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_reg    <= '0;
            wrap_reg <= 1'b0;
        end else if (load) begin
            q_reg    <= WIDTH'(conta_clamp(32'(d), MAX_VAL));
            wrap_reg <= 1'b0;
        end else if (enable) begin
            if (up_down == CONTA_UP) begin
`ifdef CONTA_SATURATE_EN
                // Pulse only on the step that arrives at the limit, never while parked there.
                if (at_max) begin
                    wrap_reg <= 1'b0;
                end else begin
                    q_reg    <= q_reg + ONE;
                    wrap_reg <= ((q_reg + ONE) == MAX_Q);
                end
`else
                if (at_max) begin
                    q_reg    <= '0;
                    wrap_reg <= 1'b1;
                end else begin
                    q_reg    <= q_reg + ONE;
                    wrap_reg <= 1'b0;
                end
`endif
            end else begin
`ifdef CONTA_SATURATE_EN
                if (at_zero) begin
                    wrap_reg <= 1'b0;
                end else begin
                    q_reg    <= q_reg - ONE;
                    wrap_reg <= (q_reg == ONE);
                end
`else
                if (at_zero) begin
                    q_reg    <= MAX_Q;
                    wrap_reg <= 1'b1;
                end else begin
                    q_reg    <= q_reg - ONE;
                    wrap_reg <= 1'b0;
                end
`endif
            end
        end else begin
            wrap_reg <= 1'b0;
        end
    end

    assign q    = q_reg;
    assign wrap = wrap_reg;

endmodule

// File: tb/tb_conta_up_down_mod.sv
// Scoreboard bench for conta_up_down_mod (WIDTH=4, MAX_VAL=9), both build variants.
module tb_conta_up_down_mod;
    import conta_pkg::*;

`ifdef CONTA_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       up_down = 1'b0;
    logic       load = 1'b0;
    logic [3:0] d = '0;
    logic [3:0] q;
    logic       wrap;

    typedef struct {
        logic [3:0] q;
        logic       w;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    conta_up_down_mod #(
        .WIDTH   (4),
        .MAX_VAL (9)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .up_down (up_down),
        .load    (load),
        .d       (d),
        .q       (q),
        .wrap    (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] aq, input logic aw,
                         input logic [3:0] eq, input logic ew);
        total++;
        if (aq !== eq || aw !== ew) begin
            bad++;
            $display("FAIL %s: got q=%0d wrap=%0b, want q=%0d wrap=%0b", name, aq, aw, eq, ew);
        end else begin
            $display("ok   %s: q=%0d wrap=%0b", name, aq, aw);
        end
    endtask

    // Monitor: each clock edge produces one registered result; pop and compare it.
    exp_t e;
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.name, q, wrap, e.q, e.w);
        end
    end

    task automatic step(input logic en, input logic ud, input logic ld, input logic [3:0] dv,
                        input logic [3:0] eq, input logic ew, input string name);
        exp_t x;
        @(negedge clk);
        enable  = en;
        up_down = ud;
        load    = ld;
        d       = dv;
        x.q = eq;
        x.w = ew;
        x.name = name;
        sb.push_back(x);
    endtask

    initial begin
        #1 reset = 1'b1;
        #1 check("reset_init", q, wrap, 4'd0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Count to 7, then hit reset between edges.
        for (int i = 1; i <= 7; i++)
            step(1'b1, CONTA_UP, 1'b0, 4'd0, 4'(i), 1'b0, "t1_up");
        @(posedge clk);
        #3;
        enable = 1'b0;
        reset  = 1'b1;
        #1 check("t1_async_reset", q, wrap, 4'd0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // 12 up counts from 0.
        for (int i = 1; i <= 12; i++) begin
            if (SAT)
                step(1'b1, CONTA_UP, 1'b0, 4'd0, (i > 9) ? 4'd9 : 4'(i), (i == 9), "t2_up");
            else
                step(1'b1, CONTA_UP, 1'b0, 4'd0, 4'(i % 10), (i == 10), "t2_up");
        end

        // Down from 0 (load wins over a simultaneous down count).
        step(1'b1, CONTA_DOWN, 1'b1, 4'd0, 4'd0, 1'b0, "t3_load0");
        step(1'b1, CONTA_DOWN, 1'b0, 4'd0, SAT ? 4'd0 : 4'd9, !SAT, "t3_down_a");
        step(1'b1, CONTA_DOWN, 1'b0, 4'd0, SAT ? 4'd0 : 4'd8, 1'b0, "t3_down_b");
        step(1'b1, CONTA_DOWN, 1'b0, 4'd0, SAT ? 4'd0 : 4'd7, 1'b0, "t3_down_c");

        // Load clamp and exact values.
        step(1'b1, CONTA_UP,   1'b1, 4'd13, 4'd9, 1'b0, "t4_clamp13");
        step(1'b1, CONTA_DOWN, 1'b1, 4'd4,  4'd4, 1'b0, "t4_load4");
        step(1'b0, CONTA_UP,   1'b1, 4'd15, 4'd9, 1'b0, "t4_clamp15");
        step(1'b0, CONTA_UP,   1'b1, 4'd9,  4'd9, 1'b0, "t4_load9");

        // From MAX: up count then hold drops wrap.
        step(1'b1, CONTA_UP, 1'b0, 4'd0, SAT ? 4'd9 : 4'd0, !SAT, "t4_max_up");
        step(1'b0, CONTA_UP, 1'b0, 4'd0, SAT ? 4'd9 : 4'd0, 1'b0, "t4_hold");

        // Direction toggling every cycle, then hold.
        step(1'b0, CONTA_UP,   1'b1, 4'd5, 4'd5, 1'b0, "t5_load5");
        step(1'b1, CONTA_UP,   1'b0, 4'd0, 4'd6, 1'b0, "t5_up");
        step(1'b1, CONTA_DOWN, 1'b0, 4'd0, 4'd5, 1'b0, "t5_down");
        step(1'b1, CONTA_UP,   1'b0, 4'd0, 4'd6, 1'b0, "t5_up");
        step(1'b1, CONTA_DOWN, 1'b0, 4'd0, 4'd5, 1'b0, "t5_down");
        for (int i = 0; i < 3; i++)
            step(1'b0, CONTA_UP, 1'b0, 4'd0, 4'd5, 1'b0, "t5_hold");

        // Approach the limits from one step away.
        step(1'b0, CONTA_UP, 1'b1, 4'd8, 4'd8, 1'b0, "t6_load8");
        step(1'b1, CONTA_UP, 1'b0, 4'd0, 4'd9, SAT, "t6_up_a");
        step(1'b1, CONTA_UP, 1'b0, 4'd0, SAT ? 4'd9 : 4'd0, !SAT, "t6_up_b");
        step(1'b1, CONTA_UP, 1'b0, 4'd0, SAT ? 4'd9 : 4'd1, 1'b0, "t6_up_c");
        step(1'b0, CONTA_DOWN, 1'b1, 4'd1, 4'd1, 1'b0, "t6_load1");
        step(1'b1, CONTA_DOWN, 1'b0, 4'd0, 4'd0, SAT, "t6_down_a");
        step(1'b1, CONTA_DOWN, 1'b0, 4'd0, SAT ? 4'd0 : 4'd9, !SAT, "t6_down_b");
        step(1'b0, CONTA_DOWN, 1'b0, 4'd0, SAT ? 4'd0 : 4'd9, 1'b0, "t6_hold");

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 4 && sb.size() > 0; i++)
            @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending entries, want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
